// File: rtl/cam_pattern_tx.sv
// Imager LVDS link emulator: emits 40-bit words (sync lane + 4 data lanes) with training, framing codes and a pixel ramp.
// Optional build macro CAM_TX_FRAME_CNT_EN: line 0's first IMG word carries frame_count as a frame tag.
module cam_pattern_tx #(
   parameter int WIDTH_WORDS = 4,
   parameter int LINES       = 3,
   parameter int HBLANK      = 2,
   parameter int VBLANK      = 5
) (
   input  logic        c,
   input  logic        rst,
   input  logic        en,
   input  logic        start,
   input  logic        free_run,
   output logic [39:0] txd,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_count
);
   localparam logic [2:0] S_TRAIN = 3'd0;
   localparam logic [2:0] S_SOL   = 3'd1;
   localparam logic [2:0] S_IMG   = 3'd2;
   localparam logic [2:0] S_EOL   = 3'd3;
   localparam logic [2:0] S_HBL   = 3'd4;
   localparam logic [2:0] S_VBL   = 3'd5;

   localparam logic [7:0] SY_TR  = 8'h3A;
   localparam logic [7:0] SY_FS  = 8'hAA;
   localparam logic [7:0] SY_LS  = 8'h2A;
   localparam logic [7:0] SY_IMG = 8'h0D;
   localparam logic [7:0] SY_LE  = 8'h12;
   localparam logic [7:0] SY_FE  = 8'h32;
   localparam logic [7:0] SY_BL  = 8'h15;

   localparam logic [11:0] WORD_LAST = 12'(WIDTH_WORDS - 1);
   localparam logic [11:0] LINE_LAST = 12'(LINES - 1);
   localparam logic [7:0]  HBL_LAST  = 8'(HBLANK - 1);
   localparam logic [7:0]  VBL_LAST  = 8'(VBLANK - 1);

   logic [2:0]       state_q, state_d;
   logic [11:0]      word_q, word_d;
   logic [11:0]      line_q, line_d;
   logic [7:0]       blk_q, blk_d;
   logic [15:0]      fcnt_q, fcnt_d;
   logic [39:0]      txd_q, txd_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             line_end;
   logic [3:0][7:0]  pix;

   // Next state and counters; txd is then built from the next state so every output is a flop.
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      line_d   = line_q;
      blk_d    = blk_q;
      fcnt_d   = fcnt_q;
      line_end = 1'b0;
      if (!en) begin
         state_d = S_TRAIN;
         word_d  = '0;
         line_d  = '0;
         blk_d   = '0;
      end else begin
         case (state_q)
            S_TRAIN: begin
               if (start) begin
                  state_d = S_SOL;
                  word_d  = '0;
                  line_d  = '0;
                  blk_d   = '0;
               end
            end
            S_SOL: begin
               state_d = S_IMG;
               word_d  = '0;
            end
            S_IMG: begin
               if (word_q == WORD_LAST) state_d = S_EOL;
               else                     word_d  = word_q + 12'd1;
            end
            S_EOL: begin
               if (HBLANK == 0) line_end = 1'b1;
               else begin
                  state_d = S_HBL;
                  blk_d   = '0;
               end
            end
            S_HBL: begin
               if (blk_q == HBL_LAST) line_end = 1'b1;
               else                   blk_d    = blk_q + 8'd1;
            end
            S_VBL: begin
               if (blk_q == VBL_LAST) begin
                  fcnt_d = fcnt_q + 16'd1;
                  state_d = (free_run || start) ? S_SOL : S_TRAIN;
                  word_d  = '0;
                  line_d  = '0;
                  blk_d   = '0;
               end else begin
                  blk_d = blk_q + 8'd1;
               end
            end
            default: begin
               state_d = S_TRAIN;
               word_d  = '0;
               line_d  = '0;
               blk_d   = '0;
            end
         endcase
         if (line_end) begin
            blk_d = '0;
            if (line_q == LINE_LAST) state_d = S_VBL;
            else begin
               state_d = S_SOL;
               line_d  = line_q + 12'd1;
            end
         end
      end

      busy_d = (state_d != S_TRAIN);
      done_d = (state_d == S_VBL) && (blk_d == VBL_LAST);

      // Ramp is (line + 4*word + lane) mod 256, so only the low bits of each counter matter.
      for (int k = 0; k < 4; k++)
         pix[k] = line_d[7:0] + {word_d[5:0], 2'b00} + 8'(k);

      case (state_d)
         S_TRAIN: txd_d = {5{SY_TR}};
         S_SOL:   txd_d = {((line_d == 12'd0) ? SY_FS : SY_LS), 32'h0};
         S_IMG:   txd_d = {SY_IMG, pix};
         S_EOL:   txd_d = {((line_d == LINE_LAST) ? SY_FE : SY_LE), 32'h0};
         default: txd_d = {SY_BL, 32'h0};
      endcase
`ifdef CAM_TX_FRAME_CNT_EN
      if (state_d == S_IMG && line_d == 12'd0 && word_d == 12'd0)
         txd_d = {SY_IMG, 16'h0, fcnt_q};
`endif
   end

   always_ff @(posedge c) begin
      if (rst) begin
         state_q <= S_TRAIN;
         word_q  <= '0;
         line_q  <= '0;
         blk_q   <= '0;
         fcnt_q  <= '0;
         txd_q   <= 40'h3A3A3A3A3A;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         line_q  <= line_d;
         blk_q   <= blk_d;
         fcnt_q  <= fcnt_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign txd         = txd_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign frame_count = fcnt_q;
endmodule

// File: tb/tb_cam_pattern_tx.sv
// Bench for cam_pattern_tx: a default-size and a wide-line instance checked every cycle against a frame-position model.
module tb_cam_pattern_tx;
   localparam int W0 = 4,  L0 = 3, H0 = 2, V0 = 5;
   localparam int W1 = 80, L1 = 2, H1 = 0, V1 = 1;
   localparam int FL0 = L0 * (W0 + 2 + H0) + V0;
   localparam int FL1 = L1 * (W1 + 2 + H1) + V1;

   logic c = 1'b0;
   logic rst, en, start, free_run;
   logic [39:0] txd0, txd1;
   logic busy0, busy1, fd0, fd1;
   logic [15:0] fc0, fc1;
   int n_chk = 0, n_fail = 0;
   bit checking = 1'b0;

   always #5 c = ~c;

   cam_pattern_tx #(.WIDTH_WORDS(W0), .LINES(L0), .HBLANK(H0), .VBLANK(V0)) u0 (
      .c(c), .rst(rst), .en(en), .start(start), .free_run(free_run),
      .txd(txd0), .busy(busy0), .frame_done(fd0), .frame_count(fc0));
   cam_pattern_tx #(.WIDTH_WORDS(W1), .LINES(L1), .HBLANK(H1), .VBLANK(V1)) u1 (
      .c(c), .rst(rst), .en(en), .start(start), .free_run(free_run),
      .txd(txd1), .busy(busy1), .frame_done(fd1), .frame_count(fc1));

   // Model state: whether a frame is on the wire, position within it, completed frames.
   typedef struct packed {
      logic        act;
      int          pos;
      logic [15:0] fc;
   } mst_t;
   mst_t m0, m1;

   function automatic mst_t step(mst_t m, int flen, logic r, logic e, logic s, logic f);
      mst_t n = m;
      if (r) begin
         n.act = 1'b0; n.pos = 0; n.fc = 16'h0;
      end else if (!e) begin
         n.act = 1'b0; n.pos = 0;
      end else if (!m.act) begin
         if (s) begin n.act = 1'b1; n.pos = 0; end
      end else if (m.pos == flen - 1) begin
         n.fc = m.fc + 16'd1;
         if (f || s) n.pos = 0;
         else        n.act = 1'b0;
      end else begin
         n.pos = m.pos + 1;
      end
      return n;
   endfunction

   function automatic logic [39:0] exp_word(mst_t m, int ww, int nl, int hb);
      int ll, l, o;
      logic [7:0]  sy;
      logic [31:0] d;
      if (!m.act) return 40'h3A3A3A3A3A;
      ll = ww + 2 + hb;
      l  = m.pos / ll;
      o  = m.pos % ll;
      d  = 32'h0;
      if (l >= nl)        sy = 8'h15;
      else if (o == 0)    sy = (l == 0) ? 8'hAA : 8'h2A;
      else if (o <= ww) begin
         sy = 8'h0D;
         for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'((l + 4 * (o - 1) + k) % 256);
`ifdef CAM_TX_FRAME_CNT_EN
         if (l == 0 && o == 1) d = {16'h0, m.fc};
`endif
      end
      else if (o == ww + 1) sy = (l == nl - 1) ? 8'h32 : 8'h12;
      else                  sy = 8'h15;
      return {sy, d};
   endfunction

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge c) begin
      m0 = step(m0, FL0, rst, en, start, free_run);
      m1 = step(m1, FL1, rst, en, start, free_run);
   end

   always @(negedge c) begin
      if (checking) begin
         chk("u0_txd",   txd0, exp_word(m0, W0, L0, H0));
         chk("u0_busy",  {39'h0, busy0}, {39'h0, m0.act});
         chk("u0_done",  {39'h0, fd0}, {39'h0, (m0.act && m0.pos == FL0 - 1)});
         chk("u0_count", {24'h0, fc0}, {24'h0, m0.fc});
         chk("u1_txd",   txd1, exp_word(m1, W1, L1, H1));
         chk("u1_busy",  {39'h0, busy1}, {39'h0, m1.act});
         chk("u1_done",  {39'h0, fd1}, {39'h0, (m1.act && m1.pos == FL1 - 1)});
         chk("u1_count", {24'h0, fc1}, {24'h0, m1.fc});
      end
   end

   logic [39:0] rec0 [0:150];
   logic [39:0] rec1 [0:150];
   logic        rdn0 [0:150];
   logic [15:0] rfc0 [0:150];
   logic [39:0] img0_exp, img0b_exp;

   initial begin
`ifdef CAM_TX_FRAME_CNT_EN
      img0_exp  = 40'h0D00000000;
      img0b_exp = 40'h0D00000001;
`else
      img0_exp  = 40'h0D03020100;
      img0b_exp = 40'h0D03020100;
`endif
      rst = 1'b1; en = 1'b0; start = 1'b0; free_run = 1'b0;
      repeat (3) @(negedge c);
      checking = 1'b1;
      rst = 1'b0;
      en  = 1'b1;
      // Enabled, no start: training forever
      repeat (5) begin
         @(negedge c);
         chk("idle_txd", txd0, 40'h3A3A3A3A3A);
         chk("idle_busy", {39'h0, busy0}, 40'h0);
      end
      chk("idle_count", {24'h0, fc0}, 40'h0);

      // Single directed frame, start sampled at edge N
      start = 1'b1;
      for (int k = 1; k <= 150; k++) begin
         @(negedge c);
         start = 1'b0;
         rec0[k] = txd0; rec1[k] = txd1; rdn0[k] = fd0; rfc0[k] = fc0;
      end
      chk("lit_fs",      rec0[1],  40'hAA00000000);
      chk("lit_img0",    rec0[2],  img0_exp);
      chk("lit_img3",    rec0[5],  40'h0D0F0E0D0C);
      chk("lit_le",      rec0[6],  40'h1200000000);
      chk("lit_hbl",     rec0[8],  40'h1500000000);
      chk("lit_ls",      rec0[9],  40'h2A00000000);
      chk("lit_l1w0",    rec0[10], 40'h0D04030201);
      chk("lit_fe",      rec0[22], 40'h3200000000);
      chk("lit_vbl",     rec0[25], 40'h1500000000);
      chk("lit_done28",  {39'h0, rdn0[28]}, 40'h0);
      chk("lit_done29",  {39'h0, rdn0[29]}, 40'h1);
      chk("lit_cnt29",   {24'h0, rfc0[29]}, 40'h0);
      chk("lit_cnt30",   {24'h0, rfc0[30]}, 40'h1);
      chk("lit_tr30",    rec0[30], 40'h3A3A3A3A3A);
      chk("wide_w63",    {32'h0, rec1[65][7:0]}, 40'hFC);
      chk("wide_wrap",   {32'h0, rec1[66][7:0]}, 40'h00);
      chk("wide_ls",     rec1[83], 40'h2A00000000);
      chk("wide_l1w63",  {32'h0, rec1[147][31:24]}, 40'h00);
      repeat (20) @(negedge c);

      // Abort on line 1 word 1, then restart
      start = 1'b1;
      @(negedge c); start = 1'b0;
      repeat (10) @(negedge c);
      chk("abort_pre", txd0, 40'h0D08070605);
      en = 1'b0;
      @(negedge c);
      chk("abort_tr",    txd0, 40'h3A3A3A3A3A);
      chk("abort_busy",  {39'h0, busy0}, 40'h0);
      chk("abort_count", {24'h0, fc0}, 40'h1);
      en = 1'b1;
      @(negedge c);
      chk("reen_tr", txd0, 40'h3A3A3A3A3A);
      start = 1'b1;
      @(negedge c); start = 1'b0;
      chk("restart_fs", txd0, 40'hAA00000000);
      @(negedge c);
      chk("restart_img0", txd0, img0b_exp);
      repeat (40) @(negedge c);

      // Mid-frame start ignored; start on last VBL chains the next frame
      start = 1'b1;
      @(negedge c); start = 1'b0;
      repeat (9) @(negedge c);
      start = 1'b1;
      @(negedge c); start = 1'b0;
      chk("midstart_ign", txd0, 40'h0D08070605);
      repeat (18) @(negedge c);
      chk("last_vbl", {39'h0, fd0}, 40'h1);
      start = 1'b1;
      @(negedge c); start = 1'b0;
      chk("chain_fs",    txd0, 40'hAA00000000);
      chk("chain_count", {24'h0, fc0}, 40'h3);
      repeat (40) @(negedge c);

      // Free run: FS every FL0 cycles without further starts
      free_run = 1'b1;
      start = 1'b1;
      @(negedge c); start = 1'b0;
      chk("fr_fs1", txd0, 40'hAA00000000);
      repeat (28) @(negedge c);
      chk("fr_pre", txd0, 40'h1500000000);
      @(negedge c);
      chk("fr_fs2", txd0, 40'hAA00000000);
      repeat (29) @(negedge c);
      chk("fr_count", {24'h0, fc0}, 40'h6);
      free_run = 1'b0;
      repeat (40) @(negedge c);

      // Randomized traffic, including mid-frame resets and enable drops
      for (int i = 0; i < 4000; i++) begin
         @(negedge c);
         rst = ($urandom_range(0, 1499) == 0);
         if (en) begin
            if ($urandom_range(0, 299) == 0) en = 1'b0;
         end else if ($urandom_range(0, 7) == 0) begin
            en = 1'b1;
         end
         start = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 199) == 0) free_run = ~free_run;
      end
      @(negedge c);
      rst = 1'b0; start = 1'b0;
      repeat (3) @(negedge c);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
